fetch_stage: RTL and testbench

Instruction fetch stage of the MIPS core. Holds the PC, issues one-at-a-time requests to instruction memory, and loads the returned word into the IF/ID register. The IF/ID register drives `id_op`/`id_funct` into the main and ALU decoders, and `id_instr` into the datapath. Handles stall, flush, branch redirect (`pcsrc`) and jump redirect, with jump targets formed from the decoded instruction.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, one-outstanding imem requests, IF/ID register (skid buffer when FETCH_SKID_EN is defined).
// Latency: request accepted at edge N, earliest response in cycle N+1, IF/ID loaded at the edge ending the response cycle.
// Backpressure: stall holds IF/ID; a stalled response is skidded (FETCH_SKID_EN) or dropped and refetched.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        pcsrc,
   input  logic [31:0] branch_target,
   input  logic        jump,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [5:0]  id_op,
   output logic [5:0]  id_funct,
   output logic [31:0] id_pcplus4
);

`ifdef FETCH_SKID_EN
   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_FULL = 2'd2} state_t;
   logic [31:0] skid_q, skid_d;
`else
   typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic        idv_q, idv_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] p4_q, p4_d;

   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        jump_take;
   logic        redirect;
   logic        hold_id;
   logic        fire;

   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      hold_id   = stall && idv_q;
      jump_take = jump && idv_q && !stall;
      redirect  = pcsrc || jump_take;
      target    = pcsrc ? branch_target : {p4_q[31:28], instr_q[25:0], 2'b00};

`ifdef FETCH_SKID_EN
      imem_req  = (state_q == S_REQ) && !reset;
`else
      // Without a skid the word would be lost, so do not fetch while IF/ID is held.
      imem_req  = (state_q == S_REQ) && !reset && !hold_id;
`endif
      fire      = imem_req && imem_ready;

      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      idv_d     = idv_q;
      instr_d   = instr_q;
      p4_d      = p4_q;
`ifdef FETCH_SKID_EN
      skid_d    = skid_q;
`endif

      case (state_q)
         S_REQ: begin
            if (fire) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
               if (discard_q) begin
                  discard_d = 1'b0;
               end else if (redirect || flush) begin
                  // Squashed word: pc is either redirected below or refetched.
                  state_d = S_REQ;
               end else if (!hold_id) begin
                  instr_d = imem_rdata;
                  p4_d    = pc_plus4;
                  idv_d   = 1'b1;
                  pc_d    = pc_plus4;
               end else begin
`ifdef FETCH_SKID_EN
                  skid_d  = imem_rdata;
                  state_d = S_FULL;
`endif
               end
            end
         end
`ifdef FETCH_SKID_EN
         S_FULL: begin
            if (redirect || flush) begin
               state_d = S_REQ;
            end else if (!hold_id) begin
               instr_d = skid_q;
               p4_d    = pc_plus4;
               idv_d   = 1'b1;
               pc_d    = pc_plus4;
               state_d = S_REQ;
            end
         end
`endif
         default: state_d = S_REQ;
      endcase

      if (redirect) begin
         pc_d  = target;
         idv_d = 1'b0;
         if ((state_q == S_WAIT && !imem_rvalid) || fire) discard_d = 1'b1;
      end
      if (flush) idv_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         idv_q     <= 1'b0;
         instr_q   <= 32'd0;
         p4_q      <= 32'd0;
`ifdef FETCH_SKID_EN
         skid_q    <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         idv_q     <= idv_d;
         instr_q   <= instr_d;
         p4_q      <= p4_d;
`ifdef FETCH_SKID_EN
         skid_q    <= skid_d;
`endif
      end
   end

   assign imem_addr  = pc_q;
   assign id_valid   = idv_q;
   assign id_instr   = instr_q;
   assign id_op      = instr_q[31:26];
   assign id_funct   = instr_q[5:0];
   assign id_pcplus4 = p4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for the basic fetch, directed corner cases, then random traffic
// checked against an instruction-stream model.
module tb_fetch_stage;
   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset, imem_req, imem_ready, imem_rvalid, stall, flush, pcsrc, jump, id_valid;
   logic [31:0] imem_addr, imem_rdata, branch_target, id_instr, id_pcplus4;
   logic [5:0]  id_op, id_funct;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .pcsrc(pcsrc), .branch_target(branch_target),
      .jump(jump), .id_valid(id_valid), .id_instr(id_instr), .id_op(id_op),
      .id_funct(id_funct), .id_pcplus4(id_pcplus4)
   );

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        st;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_instr;
      logic [31:0] e_p4;
   } vec_t;

   vec_t vt [6];

   // random-phase state
   logic        pending;
   int          cnt;
   logic [31:0] paddr, exp_pc, m_instr, m_p4, tmp;
   logic        p_idv, p_stall, p_redir, p_flush, have_pre, load_ev;
   logic [31:0] p_instr, p_p4;
   int          loads;

   initial begin
      vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, RPC,           1'b0, 32'h0,         32'h0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'h0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'h0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0004, 1'b1, 32'h2008_0005, 32'h0040_0004};
      vt[4] = '{1'b0, 1'b0, 1'b1, 32'h2009_000A, 1'b0, 1'b0, 32'h0040_0004, 1'b1, 32'h2008_0005, 32'h0040_0004};
      vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008, 1'b1, 32'h2009_000A, 32'h0040_0008};

      reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; branch_target = 32'h0; jump = 1'b0;
      tick; tick;

      // basic sequential fetch, 1-cycle memory
      for (int i = 0; i < 6; i++) begin
         reset = vt[i].rst; imem_ready = vt[i].rdy; imem_rvalid = vt[i].rv;
         imem_rdata = vt[i].rd; stall = vt[i].st;
         #1;
         chk1 ("vec_req",   imem_req,   vt[i].e_req);
         chk32("vec_addr",  imem_addr,  vt[i].e_addr);
         chk1 ("vec_valid", id_valid,   vt[i].e_v);
         chk32("vec_instr", id_instr,   vt[i].e_instr);
         chk32("vec_p4",    id_pcplus4, vt[i].e_p4);
         chk32("vec_op",    {26'd0, id_op},    {26'd0, vt[i].e_instr[31:26]});
         chk32("vec_funct", {26'd0, id_funct}, {26'd0, vt[i].e_instr[5:0]});
         tick;
      end
      chk32("addi_op", {26'd0, id_op}, 32'd8);

      // branch while a request is outstanding
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; pcsrc = 1'b1; branch_target = 32'h0040_0040; tick;
      pcsrc = 1'b0; #1;
      chk1 ("br_idv",  id_valid, 1'b0);
      chk1 ("br_req",  imem_req, 1'b0);
      chk32("br_addr", imem_addr, 32'h0040_0040);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick;
      imem_rvalid = 1'b0; #1;
      chk32("br_drop", id_instr, 32'h2009_000A);
      chk1 ("br_idv2", id_valid, 1'b0);
      chk1 ("br_req2", imem_req, 1'b1);
      chk32("br_addr2", imem_addr, 32'h0040_0040);

      // jump from IF/ID
      for (int rep = 0; rep < 2; rep++) begin
         pcsrc = 1'b1; branch_target = 32'h0040_0004; tick;
         pcsrc = 1'b0; imem_ready = 1'b1; tick;
         imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0810_0010; tick;
         imem_rvalid = 1'b0;
         chk32("j_instr", id_instr, 32'h0810_0010);
         chk32("j_p4", id_pcplus4, 32'h0040_0008);
         jump = 1'b1;
         if (rep == 1) begin
            stall = 1'b1;
            repeat (3) begin
               tick;
               chk32("js_addr", imem_addr, 32'h0040_0008);
               chk1 ("js_idv", id_valid, 1'b1);
            end
            stall = 1'b0;
         end
         tick;
         jump = 1'b0; #1;
         chk32("j_addr", imem_addr, 32'h0040_0040);
         chk1 ("j_idv", id_valid, 1'b0);
         if (rep == 0) begin
            imem_ready = 1'b1; tick;
            imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0040_0040); tick;
            imem_rvalid = 1'b0;
            chk1 ("j_reload_idv", id_valid, 1'b1);
            chk32("j_reload_p4", id_pcplus4, 32'h0040_0044);
         end
      end

      // response arriving during a 4-cycle stall
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111; tick;
      imem_rvalid = 1'b0; imem_ready = 1'b1; tick;
      imem_ready = 1'b0; stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_2222; #1;
      chk1("st_req0", imem_req, 1'b0);
      tick;
      imem_rvalid = 1'b0;
      repeat (3) begin
         #1;
         chk1 ("st_req", imem_req, 1'b0);
         chk1 ("st_idv", id_valid, 1'b1);
         chk32("st_instr", id_instr, 32'h0000_1111);
         tick;
      end
      stall = 1'b0; #1;
`ifdef FETCH_SKID_EN
      chk1 ("sk_req", imem_req, 1'b0);
      chk32("sk_hold", id_instr, 32'h0000_1111);
      tick;
`else
      chk1 ("rf_req", imem_req, 1'b1);
      chk32("rf_addr", imem_addr, 32'h0040_0044);
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_2222; tick;
      imem_rvalid = 1'b0;
`endif
      chk32("st_instr2", id_instr, 32'h0000_2222);
      chk32("st_p4", id_pcplus4, 32'h0040_0048);
      chk32("st_next", imem_addr, 32'h0040_0048);

      // PC wrap
      pcsrc = 1'b1; branch_target = 32'hFFFF_FFFC; tick;
      pcsrc = 1'b0;
      chk32("w_addr0", imem_addr, 32'hFFFF_FFFC);
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_3333; tick;
      imem_rvalid = 1'b0;
      chk32("w_p4", id_pcplus4, 32'h0);
      chk32("w_addr", imem_addr, 32'h0);
      chk32("w_instr", id_instr, 32'h0000_3333);

      // reset while waiting with a live IF/ID
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; reset = 1'b1; tick;
      #1;
      chk1 ("rs_req", imem_req, 1'b0);
      chk1 ("rs_idv", id_valid, 1'b0);
      chk32("rs_instr", id_instr, 32'h0);
      chk32("rs_p4", id_pcplus4, 32'h0);
      chk32("rs_addr", imem_addr, RPC);
      reset = 1'b0; #1;
      chk1 ("rs_req2", imem_req, 1'b1);

      // flush beats stall
      imem_ready = 1'b1; tick;
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111; tick;
      imem_rvalid = 1'b0;
      chk1("fl_pre", id_valid, 1'b1);
      stall = 1'b1; flush = 1'b1; tick;
      stall = 1'b0; flush = 1'b0;
      chk1("fl_idv", id_valid, 1'b0);

      // random traffic against the instruction-stream model
      reset = 1'b1; tick; tick;
      reset = 1'b0;
      pending = 1'b0; cnt = 0; paddr = 32'h0; exp_pc = RPC; m_instr = 32'h0; m_p4 = 32'h0;
      have_pre = 1'b0; loads = 0;
      p_idv = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_flush = 1'b0; p_instr = 32'h0; p_p4 = 32'h0;
      for (int c = 0; c < 4000; c++) begin
         if (have_pre) begin
            load_ev = id_valid && (!p_idv || id_pcplus4 != p_p4);
            if (p_redir || p_flush) begin
               chk1("rnd_clear", id_valid, 1'b0);
            end else if (p_stall && p_idv) begin
               chk1 ("rnd_hold_v", id_valid, 1'b1);
               chk32("rnd_hold_i", id_instr, p_instr);
               chk32("rnd_hold_p", id_pcplus4, p_p4);
            end else if (load_ev) begin
               chk32("rnd_instr", id_instr, mem_word(exp_pc));
               chk32("rnd_p4", id_pcplus4, exp_pc + 32'd4);
               chk32("rnd_op", {26'd0, id_op}, {26'd0, id_instr[31:26]});
               m_instr = mem_word(exp_pc);
               m_p4    = exp_pc + 32'd4;
               exp_pc  = exp_pc + 32'd4;
               loads++;
            end else if (id_valid) begin
               chk32("rnd_keep", id_instr, p_instr);
            end
         end

         stall      = ($urandom % 4) == 0;
         pcsrc      = ($urandom % 25) == 0;
         tmp        = $urandom;
         branch_target = {tmp[31:2], 2'b00};
         jump       = ($urandom % 6) == 0;
         flush      = ($urandom % 50) == 0;
         imem_ready = ($urandom % 10) < 6;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pending) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(paddr);
            end
         end
         #1;

         p_idv = id_valid; p_instr = id_instr; p_p4 = id_pcplus4;
         p_stall = stall; p_flush = flush;
         if (imem_req && imem_ready) begin
            chk1("one_outstanding", pending, 1'b0);
            chk32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
         end
         if (imem_rvalid) pending = 1'b0;
         if (imem_req && imem_ready) begin
            pending = 1'b1;
            paddr   = imem_addr;
            cnt     = $urandom_range(1, 3);
         end
         p_redir = pcsrc || (jump && id_valid && !stall);
         if (pcsrc) exp_pc = branch_target;
         else if (jump && id_valid && !stall) exp_pc = {m_p4[31:28], m_instr[25:0], 2'b00};
         have_pre = 1'b1;
         tick;
      end
      chk1("liveness", loads >= 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
